pc_sequencer: RTL and testbench

Program-counter sequencer for the 64-bit instruction-fetch datapath.
- Owns the PC register and issues fetch requests to instruction memory through a valid/ready handshake.
- Advances the PC by a fixed step on each accepted fetch, and applies branch/jump redirects and halt/resume control.
- Sits between core control (Start, Halt_req, Redirect) and the instruction-memory port.

---
 rtl/pc_seq_pkg.sv | 30 +++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_next_select.sv | 50 +++++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and default constants for the program-counter sequencer.
//   pc_state_e : sequencer FSM states (IDLE, RUN, HALTED)
//   pc_sel_e   : next-PC source select used by pc_next_select
//   *_DEF      : default parameter values for XLEN, STEP, vectors, widths
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int          XLEN_DEF         = 64;
    localparam int          STEP_DEF         = 8;
    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
    localparam logic [63:0] TRAP_VECTOR_DEF  = 64'h100;
    localparam int          ALIGN_BITS_DEF   = 2;
    localparam int          CNT_W_DEF        = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD     = 2'd0,
        SEL_INC      = 2'd1,
        SEL_REDIRECT = 2'd2,
        SEL_TRAP     = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory fetch port of the PC sequencer.
//   req   : fetch request valid (driven by the sequencer)
//   addr  : fetch address, XLEN bits (driven by the sequencer)
//   ready : memory accepts the request (driven by memory)
//
// Handshake: a fetch is transferred on a rising edge where req && ready.
// While req is high and ready is low, addr is held stable. The sequencer
// may drop req without a transfer (stall, halt, reset); memory must not
// assume a raised req stays raised.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;

    modport master (
        output req,
        output addr,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output ready
    );
endinterface

// File: rtl/pc_next_select.sv
// -----------------------------------------------------------------------------
// pc_next_select
// Combinational next-PC mux: hold / increment / redirect / trap vector.
//   sel_i      : pc_sel_e source select
//   pc_i       : current PC
//   target_i   : redirect target
//   pc_next_o  : selected next PC
// The increment is a ripple full-adder with B = STEP and Cin = 0; the carry
// out of the top bit is discarded so the PC wraps modulo 2^XLEN.
// -----------------------------------------------------------------------------
module pc_next_select
    import pc_seq_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              STEP        = STEP_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF)
) (
    input  pc_sel_e         sel_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_next_o
);

    localparam logic [XLEN-1:0] STEP_B = XLEN'(STEP);

    logic [XLEN-1:0] sum;
    logic [XLEN:0]   carry;

    always_comb begin
        carry    = '0;
        carry[0] = 1'b0;
        sum      = '0;
        for (int i = 0; i < XLEN; i++) begin
            sum[i]     = pc_i[i] ^ STEP_B[i] ^ carry[i];
            carry[i+1] = (pc_i[i] & STEP_B[i]) | (carry[i] & (pc_i[i] ^ STEP_B[i]));
        end
    end

    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            SEL_HOLD:     pc_next_o = pc_i;
            SEL_INC:      pc_next_o = sum;
            SEL_REDIRECT: pc_next_o = target_i;
            SEL_TRAP:     pc_next_o = TRAP_VECTOR;
            default:      pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the instruction-fetch datapath. Owns the PC,
// issues fetches over a valid/ready port, steps the PC on each accepted fetch,
// and applies redirects and halt/resume control.
//
// Ports:
//   clk_i             : clock, rising edge
//   rst_ni            : synchronous active-low reset
//   start_i           : leave IDLE/HALTED and begin fetching
//   stall_i           : suppress the fetch request this cycle
//   halt_req_i        : stop fetching and enter HALTED
//   redirect_valid_i  : load redirect_target_i into the PC
//   redirect_target_i : new PC
//   imem              : fetch port (master side: req, addr out; ready in)
//   pc_o              : current PC (same value as imem.addr)
//   busy_o            : state == RUN
//   halted_o          : state == HALTED
//   fetch_count_o     : saturating accepted-fetch counter
//   trap_o            : one-cycle misaligned-redirect pulse
//   state_o           : FSM state, for observation
//
// Build option: PC_MISALIGN_TRAP_EN -- when defined, a redirect whose low
// ALIGN_BITS are non-zero loads TRAP_VECTOR, forces HALTED and pulses trap_o.
// When undefined, targets load verbatim and trap_o stays 0.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              STEP         = STEP_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              ALIGN_BITS   = ALIGN_BITS_DEF,
    parameter int              CNT_W        = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stall_i,
    input  logic                  halt_req_i,
    input  logic                  redirect_valid_i,
    input  logic [XLEN-1:0]       redirect_target_i,
    pc_sequencer_if.master        imem,
    output logic [XLEN-1:0]       pc_o,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      fetch_count_o,
    output logic                  trap_o,
    output pc_state_e             state_o
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count_q;
    logic             trap_q, trap_d;

    pc_sel_e          sel;
    logic             count_en;
    logic             req;
    logic             accept;
    logic             misaligned;
    logic             trap_en;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap_en = 1'b1;
`else
    assign trap_en = 1'b0;
`endif

    assign misaligned = |redirect_target_i[ALIGN_BITS-1:0];

    assign req    = (state_q == ST_RUN) && !stall_i;
    assign accept = req && imem.ready;

    // Next-state / control. Defaults first; a misaligned redirect (when the
    // trap is built in) overrides whatever the per-state logic chose.
    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        count_en = 1'b0;
        trap_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect_valid_i) sel = SEL_REDIRECT;
                if (start_i)          state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    // Any accept in this cycle is dropped.
                    state_d = ST_HALTED;
                end else begin
                    count_en = accept;
                    if (redirect_valid_i) sel = SEL_REDIRECT;
                    else if (accept)      sel = SEL_INC;
                end
            end
            ST_HALTED: begin
                if (redirect_valid_i) sel = SEL_REDIRECT;
                if (start_i)          state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trap_en && sel == SEL_REDIRECT && misaligned) begin
            sel     = SEL_TRAP;
            state_d = ST_HALTED;
            trap_d  = 1'b1;
        end
    end

    pc_next_select #(
        .XLEN        (XLEN),
        .STEP        (STEP),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_select (
        .sel_i     (sel),
        .pc_i      (pc_q),
        .target_i  (redirect_target_i),
        .pc_next_o (pc_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
            // Saturate at all-ones rather than wrap.
            if (count_en && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign imem.req      = req;
    assign imem.addr     = pc_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALTED);
    assign fetch_count_o = count_q;
    assign trap_o        = trap_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed testbench for pc_sequencer. Inputs change 2 time units after a
// rising edge; outputs are sampled 1 unit later, well away from the edge.
// The counter width is reduced so saturation is reachable in a few cycles.
// Honors PC_MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int CNT_W_TB = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              start;
    logic              stall;
    logic              halt;
    logic              redir;
    logic [63:0]       target;
    logic              ready;
    logic [63:0]       pc;
    logic              busy;
    logic              halted;
    logic [CNT_W_TB-1:0] count;
    logic              trap;
    pc_state_e         state;

    pc_sequencer_if #(.XLEN(64)) imem_if ();
    assign imem_if.ready = ready;

    pc_sequencer #(
        .XLEN         (64),
        .STEP         (8),
        .RESET_VECTOR (64'h0),
        .TRAP_VECTOR  (64'h100),
        .ALIGN_BITS   (2),
        .CNT_W        (CNT_W_TB)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .stall_i           (stall),
        .halt_req_i        (halt),
        .redirect_valid_i  (redir),
        .redirect_target_i (target),
        .imem              (imem_if),
        .pc_o              (pc),
        .busy_o            (busy),
        .halted_o          (halted),
        .fetch_count_o     (count),
        .trap_o            (trap),
        .state_o           (state)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        stall  = 1'b0;
        halt   = 1'b0;
        redir  = 1'b0;
        target = 64'h0;
        ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state and basic fetch stream
        do_reset();
        settle();
        check("rst_pc", pc, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_req", 64'(imem_if.req), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_state", 64'(state), 64'(ST_IDLE));

        start_run();
        ready = 1'b1;
        exp_q = '{64'd0, 64'd8, 64'd16, 64'd24};
        for (int i = 0; i < 4; i++) begin
            settle();
            check("fetch_req", 64'(imem_if.req), 64'd1);
            check("fetch_addr", imem_if.addr, exp_q.pop_front());
            tick();
        end
        ready = 1'b0;
        settle();
        check("fetch_count4", 64'(count), 64'd4);
        check("fetch_busy", 64'(busy), 64'd1);
        check("fetch_pc32", pc, 64'd32);

        // memory not ready: request held stable; stall drops it
        do_reset();
        start_run();
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_req", 64'(imem_if.req), 64'd1);
            check("hold_addr", imem_if.addr, 64'd16);
            check("hold_count", 64'(count), 64'd2);
            tick();
        end
        stall = 1'b1;
        settle();
        check("stall_req", 64'(imem_if.req), 64'd0);
        ready = 1'b1;
        tick();
        settle();
        check("stall_addr", imem_if.addr, 64'd16);
        check("stall_count", 64'(count), 64'd2);
        stall = 1'b0;
        ready = 1'b0;

        // redirect beats increment; accept still counted
        do_reset();
        start_run();
        ready = 1'b1;
        tick();
        redir  = 1'b1;
        target = 64'h2000;
        tick();
        redir = 1'b0;
        ready = 1'b0;
        settle();
        check("redir_addr", imem_if.addr, 64'h2000);
        check("redir_count", 64'(count), 64'd2);
        // redirect applies while stalled; no accept
        stall  = 1'b1;
        redir  = 1'b1;
        target = 64'h3000;
        ready  = 1'b1;
        tick();
        idle_inputs();
        settle();
        check("stall_redir_pc", pc, 64'h3000);
        check("stall_redir_count", 64'(count), 64'd2);

        // halt with simultaneous accept, then resume
        do_reset();
        start_run();
        ready = 1'b1;
        tick();
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt  = 1'b0;
        ready = 1'b0;
        settle();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_pc", pc, 64'd24);
        check("halt_count", 64'(count), 64'd3);
        check("halt_req", 64'(imem_if.req), 64'd0);
        start_run();
        settle();
        check("resume_busy", 64'(busy), 64'd1);
        check("resume_addr", imem_if.addr, 64'd24);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        settle();
        check("resume_pc", pc, 64'd32);
        check("resume_count", 64'(count), 64'd4);
        halt = 1'b1;
        tick();
        halt   = 1'b0;
        redir  = 1'b1;
        target = 64'h80;
        tick();
        settle();
        check("halted_redir_pc", pc, 64'h80);
        check("halted_redir_st", 64'(halted), 64'd1);
        target = 64'h90;
        start  = 1'b1;
        tick();
        idle_inputs();
        settle();
        check("start_redir_pc", pc, 64'h90);
        check("start_redir_busy", 64'(busy), 64'd1);

        // IDLE redirect, wrap, reset mid-run
        do_reset();
        redir  = 1'b1;
        target = 64'h40;
        tick();
        redir = 1'b0;
        settle();
        check("idle_redir_pc", pc, 64'h40);
        check("idle_redir_state", 64'(state), 64'(ST_IDLE));
        start_run();
        redir  = 1'b1;
        target = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redir = 1'b0;
        settle();
        check("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFF8);
        ready = 1'b1;
        tick();
        settle();
        check("wrap_pc", pc, 64'h0);
        check("wrap_count", 64'(count), 64'd1);
        tick();
        settle();
        check("post_wrap_pc", pc, 64'h8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ready = 1'b0;
        settle();
        check("midrun_rst_pc", pc, 64'h0);
        check("midrun_rst_count", 64'(count), 64'd0);
        check("midrun_rst_state", 64'(state), 64'(ST_IDLE));

        // counter saturation (3-bit counter, 10 accepts)
        do_reset();
        start_run();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ready = 1'b0;
        settle();
        check("sat_count", 64'(count), 64'd7);
        check("sat_pc", pc, 64'd80);

        // misaligned redirect
        do_reset();
        start_run();
        redir  = 1'b1;
        target = 64'h1002;
        tick();
        redir = 1'b0;
        settle();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", pc, 64'h100);
        check("mis_halted", 64'(halted), 64'd1);
        check("mis_trap", 64'(trap), 64'd1);
        tick();
        settle();
        check("mis_trap_clear", 64'(trap), 64'd0);
        check("mis_still_halted", 64'(halted), 64'd1);
`else
        check("mis_pc", pc, 64'h1002);
        check("mis_busy", 64'(busy), 64'd1);
        check("mis_trap", 64'(trap), 64'd0);
        tick();
        settle();
        check("mis_trap_later", 64'(trap), 64'd0);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
